// File: rtl/decode_stage.sv
// Decode stage: RV32I subset decode, 32x32 register file with write-through bypass, D/E pipeline register.
// Define DECODE_MUL_EN to decode R-type funct7=0000001/funct3=000 as MUL.
module decode_stage #(
    parameter int WORD_SIZE = 32,
    parameter int REG_COUNT = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          InstrD,
    input  logic [WORD_SIZE-1:0] PCD,
    input  logic [WORD_SIZE-1:0] PCPlus4D,
    input  logic                 TakingBranchD,
    input  logic                 RegWriteW,
    input  logic [4:0]           RdW,
    input  logic [WORD_SIZE-1:0] ResultW,
    input  logic                 StallE,
    input  logic                 FlushE,
    output logic [4:0]           Rs1D,
    output logic [4:0]           Rs2D,
    output logic [WORD_SIZE-1:0] RD1E,
    output logic [WORD_SIZE-1:0] RD2E,
    output logic [WORD_SIZE-1:0] ImmExtE,
    output logic [WORD_SIZE-1:0] PCE,
    output logic [WORD_SIZE-1:0] PCPlus4E,
    output logic [4:0]           Rs1E,
    output logic [4:0]           Rs2E,
    output logic [4:0]           RdE,
    output logic [2:0]           Funct3E,
    output logic                 RegWriteE,
    output logic                 MemWriteE,
    output logic                 JumpE,
    output logic                 BranchE,
    output logic                 ALUSrcE,
    output logic                 TakingBranchE,
    output logic [1:0]           ResultSrcE,
    output logic [3:0]           ALUControlE
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLT   = 4'b0101,
        ALU_SLL   = 4'b0110,
        ALU_SRL   = 4'b0111,
        ALU_SRA   = 4'b1000,
        ALU_MUL   = 4'b1001,
        ALU_PASSB = 4'b1010
    } aluOpT;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rdD;
    logic       isRType;
    logic       f7Zero;
    logic       f7Alt;

    assign opcode  = InstrD[6:0];
    assign rdD     = InstrD[11:7];
    assign funct3  = InstrD[14:12];
    assign Rs1D    = InstrD[19:15];
    assign Rs2D    = InstrD[24:20];
    assign funct7  = InstrD[31:25];
    assign isRType = (opcode == OP_R);
    assign f7Zero  = (funct7 == 7'b0000000);
    assign f7Alt   = (funct7 == 7'b0100000);

    logic [WORD_SIZE-1:0] immI, immS, immB, immJ, immU;

    assign immI = {{(WORD_SIZE-12){InstrD[31]}}, InstrD[31:20]};
    assign immS = {{(WORD_SIZE-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
    assign immB = {{(WORD_SIZE-13){InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
    assign immJ = {{(WORD_SIZE-21){InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
    assign immU = WORD_SIZE'({InstrD[31:12], 12'b0});

    logic [WORD_SIZE-1:0] regFile [REG_COUNT];
    logic [WORD_SIZE-1:0] rd1D, rd2D;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regFile[i] <= '0;
            end
        end else if (RegWriteW && (RdW != 5'd0)) begin
            regFile[RdW] <= ResultW;
        end
    end

    // Write-through bypass lets an instruction see a value being written back in the same cycle.
    assign rd1D = (Rs1D == 5'd0) ? '0 :
                  (RegWriteW && (RdW == Rs1D)) ? ResultW : regFile[Rs1D];
    assign rd2D = (Rs2D == 5'd0) ? '0 :
                  (RegWriteW && (RdW == Rs2D)) ? ResultW : regFile[Rs2D];

    aluOpT aluOp;
    logic  aluOk;

    // Shared funct decode for R-type and I-ALU; funct7 only matters for R-type and for shifts.
    always_comb begin
        aluOp = ALU_ADD;
        aluOk = 1'b1;
        case (funct3)
            3'b000: begin
                if (!isRType || f7Zero) aluOp = ALU_ADD;
                else if (f7Alt) aluOp = ALU_SUB;
`ifdef DECODE_MUL_EN
                else if (funct7 == 7'b0000001) aluOp = ALU_MUL;
`endif
                else aluOk = 1'b0;
            end
            3'b001: begin
                aluOp = ALU_SLL;
                aluOk = f7Zero;
            end
            3'b010: begin
                aluOp = ALU_SLT;
                aluOk = !isRType || f7Zero;
            end
            3'b100: begin
                aluOp = ALU_XOR;
                aluOk = !isRType || f7Zero;
            end
            3'b101: begin
                if (f7Zero) aluOp = ALU_SRL;
                else if (f7Alt) aluOp = ALU_SRA;
                else aluOk = 1'b0;
            end
            3'b110: begin
                aluOp = ALU_OR;
                aluOk = !isRType || f7Zero;
            end
            3'b111: begin
                aluOp = ALU_AND;
                aluOk = !isRType || f7Zero;
            end
            default: aluOk = 1'b0;
        endcase
    end

    logic                 regWriteD, memWriteD, jumpD, branchD, aluSrcD;
    logic [1:0]           resultSrcD;
    logic [3:0]           aluCtrlD;
    logic [WORD_SIZE-1:0] immExtD;

    always_comb begin
        regWriteD  = 1'b0;
        memWriteD  = 1'b0;
        jumpD      = 1'b0;
        branchD    = 1'b0;
        aluSrcD    = 1'b0;
        resultSrcD = 2'b00;
        aluCtrlD   = ALU_ADD;
        immExtD    = '0;
        case (opcode)
            OP_R: begin
                if (aluOk) begin
                    regWriteD = 1'b1;
                    aluCtrlD  = aluOp;
                end
            end
            OP_IMM: begin
                immExtD = immI;
                if (aluOk) begin
                    regWriteD = 1'b1;
                    aluSrcD   = 1'b1;
                    aluCtrlD  = aluOp;
                end
            end
            OP_LOAD: begin
                immExtD    = immI;
                regWriteD  = 1'b1;
                aluSrcD    = 1'b1;
                resultSrcD = 2'b01;
            end
            OP_STORE: begin
                immExtD   = immS;
                memWriteD = 1'b1;
                aluSrcD   = 1'b1;
            end
            OP_BRANCH: begin
                immExtD  = immB;
                branchD  = 1'b1;
                aluCtrlD = ALU_SUB;
            end
            OP_JAL: begin
                immExtD    = immJ;
                jumpD      = 1'b1;
                regWriteD  = 1'b1;
                resultSrcD = 2'b10;
            end
            OP_LUI: begin
                immExtD   = immU;
                regWriteD = 1'b1;
                aluSrcD   = 1'b1;
                aluCtrlD  = ALU_PASSB;
            end
            default: ;
        endcase
    end

    // A flush inserts a bubble but keeps the PC pair, so execute still knows where the bubble sits.
    always_ff @(posedge clk) begin
        if (rst) begin
            RD1E          <= '0;
            RD2E          <= '0;
            ImmExtE       <= '0;
            PCE           <= '0;
            PCPlus4E      <= '0;
            Rs1E          <= '0;
            Rs2E          <= '0;
            RdE           <= '0;
            Funct3E       <= '0;
            RegWriteE     <= 1'b0;
            MemWriteE     <= 1'b0;
            JumpE         <= 1'b0;
            BranchE       <= 1'b0;
            ALUSrcE       <= 1'b0;
            TakingBranchE <= 1'b0;
            ResultSrcE    <= '0;
            ALUControlE   <= '0;
        end else if (FlushE) begin
            RD1E          <= '0;
            RD2E          <= '0;
            ImmExtE       <= '0;
            Rs1E          <= '0;
            Rs2E          <= '0;
            RdE           <= '0;
            Funct3E       <= '0;
            RegWriteE     <= 1'b0;
            MemWriteE     <= 1'b0;
            JumpE         <= 1'b0;
            BranchE       <= 1'b0;
            ALUSrcE       <= 1'b0;
            TakingBranchE <= 1'b0;
            ResultSrcE    <= '0;
            ALUControlE   <= '0;
        end else if (!StallE) begin
            RD1E          <= rd1D;
            RD2E          <= rd2D;
            ImmExtE       <= immExtD;
            PCE           <= PCD;
            PCPlus4E      <= PCPlus4D;
            Rs1E          <= Rs1D;
            Rs2E          <= Rs2D;
            RdE           <= rdD;
            Funct3E       <= funct3;
            RegWriteE     <= regWriteD;
            MemWriteE     <= memWriteD;
            JumpE         <= jumpD;
            BranchE       <= branchD;
            ALUSrcE       <= aluSrcD;
            TakingBranchE <= TakingBranchD;
            ResultSrcE    <= resultSrcD;
            ALUControlE   <= aluCtrlD;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions push expected D/E contents, a negedge monitor checks them.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        TakingBranchD, RegWriteW, StallE, FlushE;
    logic [4:0]  RdW;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [2:0]  Funct3E;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, TakingBranchE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .TakingBranchD(TakingBranchD), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .StallE(StallE), .FlushE(FlushE), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .Funct3E(Funct3E),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .TakingBranchE(TakingBranchE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE)
    );

    // Control word layout: {RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc[1:0], ALUControl[3:0]}
    localparam logic [10:0] CTL_BUBBLE = 11'b00000_00_0000;
    localparam logic [10:0] CTL_ADDI   = 11'b10001_00_0000;
    localparam logic [10:0] CTL_ADD    = 11'b10000_00_0000;
    localparam logic [10:0] CTL_SUB    = 11'b10000_00_0001;
    localparam logic [10:0] CTL_BEQ    = 11'b00010_00_0001;
    localparam logic [10:0] CTL_LUI    = 11'b10001_00_1010;
    localparam logic [10:0] CTL_SW     = 11'b01001_00_0000;
    localparam logic [10:0] CTL_JAL    = 11'b10100_10_0000;
    localparam logic [10:0] CTL_LW     = 11'b10001_01_0000;
    localparam logic [10:0] CTL_SRAI   = 11'b10001_00_1000;
`ifdef DECODE_MUL_EN
    localparam logic [10:0] CTL_MULX   = 11'b10000_00_1001;
`else
    localparam logic [10:0] CTL_MULX   = CTL_BUBBLE;
`endif

    typedef struct {
        string       name;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [10:0] ctl;
        logic        take;
    } expT;

    expT  scoreboard[$];
    expT  cur;
    expT  noExp;
    int   compared   = 0;
    int   mismatched = 0;
    logic issueCheck = 1'b0;
    logic outValid   = 1'b0;

    function automatic expT mkExp(input string n, input logic [31:0] rd1, input logic [31:0] rd2,
                                  input logic [31:0] imm, input logic [31:0] pc, input logic [31:0] pc4,
                                  input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                  input logic [2:0] f3, input logic [10:0] ctl, input logic take);
        expT e;
        e.name = n; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm; e.pc = pc; e.pc4 = pc4;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.f3 = f3; e.ctl = ctl; e.take = take;
        return e;
    endfunction

    task automatic cmp(input string tag, input string field, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s.%s got %h expected %h", tag, field, got, want);
        end
    endtask

    task automatic checkOutput(input expT e);
        cmp(e.name, "RD1E", RD1E, e.rd1);
        cmp(e.name, "RD2E", RD2E, e.rd2);
        cmp(e.name, "ImmExtE", ImmExtE, e.imm);
        cmp(e.name, "PCE", PCE, e.pc);
        cmp(e.name, "PCPlus4E", PCPlus4E, e.pc4);
        cmp(e.name, "Rs1E", 32'(Rs1E), 32'(e.rs1));
        cmp(e.name, "Rs2E", 32'(Rs2E), 32'(e.rs2));
        cmp(e.name, "RdE", 32'(RdE), 32'(e.rd));
        cmp(e.name, "Funct3E", 32'(Funct3E), 32'(e.f3));
        cmp(e.name, "ctrl", 32'({RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE}), 32'(e.ctl));
        cmp(e.name, "TakingBranchE", 32'(TakingBranchE), 32'(e.take));
    endtask

    task automatic applyStimulus(input string name, input logic rstV, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic take, input logic wen,
                                 input logic [4:0] rdw, input logic [31:0] res, input logic stall,
                                 input logic flush, input logic chk, input expT e);
        rst = rstV; InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4; TakingBranchD = take;
        RegWriteW = wen; RdW = rdw; ResultW = res; StallE = stall; FlushE = flush;
        issueCheck = chk;
        if (chk) scoreboard.push_back(e);
        #2;
        cmp(name, "Rs1D", 32'(Rs1D), 32'(instr[19:15]));
        cmp(name, "Rs2D", 32'(Rs2D), 32'(instr[24:20]));
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) outValid <= issueCheck;

    always @(negedge clk) begin
        if (outValid) begin
            if (scoreboard.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL scoreboard got empty queue expected an entry");
            end else begin
                cur = scoreboard.pop_front();
                checkOutput(cur);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        noExp = mkExp("none", 0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_BUBBLE, 0);
        applyStimulus("rst0", 1, 32'hFFF00093, 32'h0FC, 0, 0, 0, 0, 0, 0, 0, noExp);
        applyStimulus("rst1", 1, 32'hFFF00093, 32'h0FC, 0, 0, 0, 0, 0, 0, 1,
            mkExp("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_BUBBLE, 0));
        applyStimulus("addi", 0, 32'hFFF00093, 32'h100, 0, 0, 0, 0, 0, 0, 1,
            mkExp("addi", 0, 0, 32'hFFFFFFFF, 32'h100, 32'h104, 0, 31, 1, 0, CTL_ADDI, 0));
        applyStimulus("bypass", 0, 32'h00028333, 32'h104, 0, 1, 5, 32'hDEADBEEF, 0, 0, 1,
            mkExp("bypass", 32'hDEADBEEF, 0, 0, 32'h104, 32'h108, 5, 0, 6, 0, CTL_ADD, 0));
        applyStimulus("x0wr", 0, 32'h005003B3, 32'h108, 0, 1, 0, 32'h1234, 0, 0, 1,
            mkExp("x0wr", 0, 32'hDEADBEEF, 0, 32'h108, 32'h10C, 0, 5, 7, 0, CTL_ADD, 0));
        applyStimulus("x0rd", 0, 32'h005003B3, 32'h10C, 0, 0, 0, 0, 0, 0, 1,
            mkExp("x0rd", 0, 32'hDEADBEEF, 0, 32'h10C, 32'h110, 0, 5, 7, 0, CTL_ADD, 0));
        applyStimulus("nop1", 0, 32'h00000013, 32'h110, 0, 1, 1, 32'h11111111, 0, 0, 1,
            mkExp("nop1", 0, 0, 0, 32'h110, 32'h114, 0, 0, 0, 0, CTL_ADDI, 0));
        applyStimulus("nop2", 0, 32'h00000013, 32'h114, 0, 1, 2, 32'h22222222, 0, 0, 1,
            mkExp("nop2", 0, 0, 0, 32'h114, 32'h118, 0, 0, 0, 0, CTL_ADDI, 0));
        applyStimulus("beq", 0, 32'h00208463, 32'h118, 1, 0, 0, 0, 0, 0, 1,
            mkExp("beq", 32'h11111111, 32'h22222222, 32'h8, 32'h118, 32'h11C, 1, 2, 8, 0, CTL_BEQ, 1));
        applyStimulus("flush", 0, 32'h00208463, 32'h11C, 1, 0, 0, 0, 0, 1, 1,
            mkExp("flush", 0, 0, 0, 32'h118, 32'h11C, 0, 0, 0, 0, CTL_BUBBLE, 0));
        applyStimulus("stall", 0, 32'h00028333, 32'h120, 0, 1, 3, 32'h33333333, 1, 0, 1,
            mkExp("stall", 0, 0, 0, 32'h118, 32'h11C, 0, 0, 0, 0, CTL_BUBBLE, 0));
        applyStimulus("afterStall", 0, 32'h00318433, 32'h124, 0, 0, 0, 0, 0, 0, 1,
            mkExp("afterStall", 32'h33333333, 32'h33333333, 0, 32'h124, 32'h128, 3, 3, 8, 0, CTL_ADD, 0));
        applyStimulus("mul", 0, 32'h022081B3, 32'h128, 0, 0, 0, 0, 0, 0, 1,
            mkExp("mul", 32'h11111111, 32'h22222222, 0, 32'h128, 32'h12C, 1, 2, 3, 0, CTL_MULX, 0));
        applyStimulus("lui", 0, 32'h80000537, 32'h12C, 0, 0, 0, 0, 0, 0, 1,
            mkExp("lui", 0, 0, 32'h80000000, 32'h12C, 32'h130, 0, 0, 10, 0, CTL_LUI, 0));
        applyStimulus("sw", 0, 32'hFE20AE23, 32'h130, 0, 0, 0, 0, 0, 0, 1,
            mkExp("sw", 32'h11111111, 32'h22222222, 32'hFFFFFFFC, 32'h130, 32'h134, 1, 2, 28, 2, CTL_SW, 0));
        applyStimulus("jal", 0, 32'hFFDFF0EF, 32'h134, 0, 0, 0, 0, 0, 0, 1,
            mkExp("jal", 0, 0, 32'hFFFFFFFC, 32'h134, 32'h138, 31, 29, 1, 7, CTL_JAL, 0));
        applyStimulus("lw", 0, 32'h7FF2A203, 32'h138, 0, 0, 0, 0, 0, 0, 1,
            mkExp("lw", 32'hDEADBEEF, 0, 32'h7FF, 32'h138, 32'h13C, 5, 31, 4, 2, CTL_LW, 0));
        applyStimulus("unknown", 0, 32'hFFFFFFFF, 32'h13C, 0, 0, 0, 0, 0, 0, 1,
            mkExp("unknown", 0, 0, 0, 32'h13C, 32'h140, 31, 31, 31, 7, CTL_BUBBLE, 0));
        applyStimulus("sub", 0, 32'h401284B3, 32'h140, 0, 0, 0, 0, 0, 0, 1,
            mkExp("sub", 32'hDEADBEEF, 32'h11111111, 0, 32'h140, 32'h144, 5, 1, 9, 0, CTL_SUB, 0));
        applyStimulus("srai", 0, 32'h4042D493, 32'h144, 0, 0, 0, 0, 0, 0, 1,
            mkExp("srai", 32'hDEADBEEF, 0, 32'h404, 32'h144, 32'h148, 5, 4, 9, 5, CTL_SRAI, 0));
        applyStimulus("illegal", 0, 32'h4012C4B3, 32'h148, 0, 0, 0, 0, 0, 0, 1,
            mkExp("illegal", 32'hDEADBEEF, 32'h11111111, 0, 32'h148, 32'h14C, 5, 1, 9, 4, CTL_BUBBLE, 0));
        applyStimulus("idle", 0, 32'h00000013, 32'h14C, 0, 0, 0, 0, 0, 0, 0, noExp);

        for (int i = 0; i < 10 && scoreboard.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        if (scoreboard.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain got %0d pending expected 0", scoreboard.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
